// File: rtl/pong_match_ctrl_if.sv
// Interface bundle for pong_match_ctrl.
// Groups the per-frame events, the player buttons and the match status
// outputs. The "slave" modport is the controller's view. The "master"
// modport is the view of whatever drives the events and consumes the
// status.
// Signalling: frame_tick, miss_left and miss_right are single-cycle
// pulses. The buttons are synchronised levels. All outputs are registered.
// No ready/valid back-pressure exists: every pulse is consumed in the
// cycle it is presented.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic       miss_left;
  logic       miss_right;
  logic       player_1_button;
  logic       player_2_button;
  logic       ball_reset;
  logic       ball_enable;
  logic       serve_dir_left;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic [1:0] winner;
  logic [2:0] state;

  modport master (
    output frame_tick, miss_left, miss_right, player_1_button, player_2_button,
    input  ball_reset, ball_enable, serve_dir_left, score_1, score_2, winner, state
  );

  modport slave (
    input  frame_tick, miss_left, miss_right, player_1_button, player_2_button,
    output ball_reset, ball_enable, serve_dir_left, score_1, score_2, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve, rally, scoring and game-over sequencing.
// Optional feature macro PONG_AUTO_SERVE_EN. When it is defined, an 8-bit
// frame counter serves automatically SERVE_DELAY_FRAMES frames into
// SERVE_WAIT. When it is undefined, only the serving player's button starts
// a rally.
// Every output comes from a register, so no input-to-output combinational
// path exists. The state is exported on bus.state for debug and display.
module pong_match_ctrl #(
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic                    CLOCK_25,
  input  logic                    RESET,
  pong_match_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_POINT      = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LP_WIN = 4'(WIN_SCORE);

  state_t     r_state;
  logic [3:0] r_score_1;
  logic [3:0] r_score_2;
  logic [1:0] r_winner;
  logic       r_serve_dir_left;
  logic       r_ball_reset;
  logic       r_ball_enable;
  logic       r_btn1_q;
  logic       r_btn2_q;

  logic       w_btn1_rise;
  logic       w_btn2_rise;
  logic       w_serve_rise;
  logic       w_any_rise;

  // Button edges: level high now, registered level low last cycle.
  assign w_btn1_rise  = bus.player_1_button & ~r_btn1_q;
  assign w_btn2_rise  = bus.player_2_button & ~r_btn2_q;
  assign w_any_rise   = w_btn1_rise | w_btn2_rise;
  // The server is the player the ball moves away from.
  assign w_serve_rise = r_serve_dir_left ? w_btn2_rise : w_btn1_rise;

`ifdef PONG_AUTO_SERVE_EN
  localparam logic [7:0] LP_DELAY = 8'(SERVE_DELAY_FRAMES);
  logic [7:0] r_frame_cnt;

  // Frame counter: counts frames in SERVE_WAIT, saturates at 255, and is
  // cleared whenever a new serve wait begins.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_frame_cnt <= 8'd0;
    end else if ((r_state == ST_IDLE && w_any_rise) ||
                 (r_state == ST_POINT && r_score_1 < LP_WIN && r_score_2 < LP_WIN)) begin
      r_frame_cnt <= 8'd0;
    end else if (r_state == ST_SERVE_WAIT && bus.frame_tick && r_frame_cnt != 8'hFF) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{bus.frame_tick, 8'(SERVE_DELAY_FRAMES)};
`endif

  // Match FSM with registered outputs and button history.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      r_state          <= ST_IDLE;
      r_score_1        <= 4'd0;
      r_score_2        <= 4'd0;
      r_winner         <= 2'b00;
      r_serve_dir_left <= 1'b0;
      r_ball_reset     <= 1'b1;
      r_ball_enable    <= 1'b0;
      r_btn1_q         <= 1'b0;
      r_btn2_q         <= 1'b0;
    end else begin
      r_btn1_q <= bus.player_1_button;
      r_btn2_q <= bus.player_2_button;
      case (r_state)
        ST_IDLE: begin
          r_ball_reset  <= 1'b1;
          r_ball_enable <= 1'b0;
          if (w_any_rise) begin
            r_score_1        <= 4'd0;
            r_score_2        <= 4'd0;
            r_winner         <= 2'b00;
            r_serve_dir_left <= 1'b0;
            r_state          <= ST_SERVE_WAIT;
          end
        end
        ST_SERVE_WAIT: begin
          if (w_serve_rise) begin
            r_state       <= ST_PLAY;
            r_ball_reset  <= 1'b0;
            r_ball_enable <= 1'b1;
          end
`ifdef PONG_AUTO_SERVE_EN
          else if (r_frame_cnt >= LP_DELAY) begin
            r_state       <= ST_PLAY;
            r_ball_reset  <= 1'b0;
            r_ball_enable <= 1'b1;
          end
`endif
        end
        ST_PLAY: begin
          if (bus.miss_left || bus.miss_right) begin
            r_state       <= ST_POINT;
            r_ball_reset  <= 1'b1;
            r_ball_enable <= 1'b0;
            // A double miss is a void point: no score, serve side kept.
            if (bus.miss_left && !bus.miss_right) begin
              if (r_score_2 != 4'hF) r_score_2 <= r_score_2 + 4'd1;
              r_serve_dir_left <= 1'b1;
            end else if (bus.miss_right && !bus.miss_left) begin
              if (r_score_1 != 4'hF) r_score_1 <= r_score_1 + 4'd1;
              r_serve_dir_left <= 1'b0;
            end
          end
        end
        ST_POINT: begin
          r_ball_reset  <= 1'b1;
          r_ball_enable <= 1'b0;
          if (r_score_1 >= LP_WIN) begin
            r_winner <= 2'b01;
            r_state  <= ST_GAME_OVER;
          end else if (r_score_2 >= LP_WIN) begin
            r_winner <= 2'b10;
            r_state  <= ST_GAME_OVER;
          end else begin
            r_state  <= ST_SERVE_WAIT;
          end
        end
        ST_GAME_OVER: begin
          r_ball_reset  <= 1'b1;
          r_ball_enable <= 1'b0;
          if (w_any_rise) r_state <= ST_IDLE;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_ball_reset  <= 1'b1;
          r_ball_enable <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state          = r_state;
  assign bus.score_1        = r_score_1;
  assign bus.score_2        = r_score_2;
  assign bus.winner         = r_winner;
  assign bus.serve_dir_left = r_serve_dir_left;
  assign bus.ball_reset     = r_ball_reset;
  assign bus.ball_enable    = r_ball_enable;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Testbench for pong_match_ctrl (WIN_SCORE=3, SERVE_DELAY_FRAMES=4).
// A behavioural game model predicts every output after each clock. It is
// complemented by a queue of expected scores for each point and by directed
// checks on the key scenarios.
module tb_pong_match_ctrl;
  localparam int WIN   = 3;
  localparam int DELAY = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pong_match_ctrl_if bus();

  pong_match_ctrl #(.WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(DELAY)) dut (
    .CLOCK_25 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural game model: phase is the state code the display shows.
  int m_phase, m_s1, m_s2, m_win, m_dir, m_frames, m_b1, m_b2;
  logic [7:0] exp_q[$];

  task automatic model_reset();
    m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0;
    m_frames = 0; m_b1 = 0; m_b2 = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int f, input int ml, input int mr, input int b1, input int b2);
    int press1, press2, np;
    press1 = (b1 == 1 && m_b1 == 0) ? 1 : 0;
    press2 = (b2 == 1 && m_b2 == 0) ? 1 : 0;
    np = m_phase;
    if (m_phase == 0) begin
      if (press1 + press2 > 0) begin
        m_s1 = 0; m_s2 = 0; m_win = 0; m_dir = 0; m_frames = 0; np = 1;
      end
    end else if (m_phase == 1) begin
      if ((m_dir == 1) ? press2 == 1 : press1 == 1) np = 2;
`ifdef PONG_AUTO_SERVE_EN
      else if (m_frames >= DELAY) np = 2;
`endif
      if (f == 1) m_frames = (m_frames < 255) ? m_frames + 1 : 255;
    end else if (m_phase == 2) begin
      if (ml + mr > 0) begin
        np = 3;
        if (ml == 1 && mr == 0) begin m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15; m_dir = 1; end
        if (mr == 1 && ml == 0) begin m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15; m_dir = 0; end
        exp_q.push_back(8'((m_s1 << 4) + m_s2));
      end
    end else if (m_phase == 3) begin
      if (m_s1 >= WIN) begin m_win = 1; np = 4; end
      else if (m_s2 >= WIN) begin m_win = 2; np = 4; end
      else begin m_frames = 0; np = 1; end
    end else begin
      if (press1 + press2 > 0) np = 0;
    end
    m_phase = np;
    m_b1 = b1; m_b2 = b2;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] sc;
    chk({tag, ".state"}, 8'(bus.state), 8'(m_phase));
    chk({tag, ".score_1"}, 8'(bus.score_1), 8'(m_s1));
    chk({tag, ".score_2"}, 8'(bus.score_2), 8'(m_s2));
    chk({tag, ".winner"}, 8'(bus.winner), 8'(m_win));
    chk({tag, ".serve_dir"}, 8'(bus.serve_dir_left), 8'(m_dir));
    chk({tag, ".ball_enable"}, 8'(bus.ball_enable), (m_phase == 2) ? 8'd1 : 8'd0);
    chk({tag, ".ball_reset"}, 8'(bus.ball_reset), (m_phase == 2) ? 8'd0 : 8'd1);
    if (m_phase == 3 && exp_q.size() > 0) begin
      sc = exp_q.pop_front();
      chk({tag, ".point_scores"}, {bus.score_1, bus.score_2}, sc);
    end
  endtask

  // One clock: drive inputs, advance the model, check 1 ns after the edge.
  task automatic cycle(input string tag, input int f, input int ml, input int mr, input int b1, input int b2);
    bus.frame_tick      = f[0];
    bus.miss_left       = ml[0];
    bus.miss_right      = mr[0];
    bus.player_1_button = b1[0];
    bus.player_2_button = b2[0];
    model_step(f, ml, mr, b1, b2);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 0, 0, 0, 0, 0);
  endtask

  task automatic press(input string tag, input int which);
    cycle(tag, 0, 0, 0, (which == 1) ? 1 : 0, (which == 2) ? 1 : 0);
    idle(tag);
  endtask

  // The serving player is the one the ball moves away from.
  task automatic serve(input string tag);
    press(tag, (m_dir == 1) ? 2 : 1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] st_after_ticks;
    n_tests = 0;
    n_fail  = 0;
    bus.frame_tick = 1'b0; bus.miss_left = 1'b0; bus.miss_right = 1'b0;
    bus.player_1_button = 1'b0; bus.player_2_button = 1'b0;
    rst = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle("idle");

    // Start match, then first serve by player 1.
    press("start", 1);
    chk("start.state_sw", 8'(bus.state), 8'd1);
    press("serve1", 1);
    chk("serve1.state_play", 8'(bus.state), 8'd2);

    // Point to player 1.
    cycle("miss_r", 0, 0, 1, 0, 0);
    chk("miss_r.score_1", 8'(bus.score_1), 8'd1);
    chk("miss_r.state_point", 8'(bus.state), 8'd3);
    idle("after_point");
    chk("after_point.dir", 8'(bus.serve_dir_left), 8'd0);

    // Miss outside PLAY and the wrong button are ignored.
    cycle("miss_sw", 0, 1, 0, 0, 0);
    press("wrong_btn", 2);
    chk("wrong_btn.state", 8'(bus.state), 8'd1);
    press("serve2", 1);

    // Void point on double miss.
    cycle("double", 0, 1, 1, 0, 0);
    chk("double.state_point", 8'(bus.state), 8'd3);
    idle("double_exit");

    // Player 2 wins 3 points in a row.
    for (int i = 0; i < WIN; i++) begin
      serve("serve_loop");
      cycle("miss_l", 0, 1, 0, 0, 0);
      idle("miss_l_exit");
    end
    chk("gameover.state", 8'(bus.state), 8'd4);
    chk("gameover.winner", 8'(bus.winner), 8'd2);
    chk("gameover.score_2", 8'(bus.score_2), 8'(WIN));
    press("to_idle", 2);
    chk("to_idle.state", 8'(bus.state), 8'd0);
    press("restart", 1);
    chk("restart.score_2", 8'(bus.score_2), 8'd0);

    // Frame ticks in SERVE_WAIT without buttons.
    for (int i = 0; i < 10; i++) begin
      cycle("ticks", 1, 0, 0, 0, 0);
      idle("ticks_gap");
    end
`ifdef PONG_AUTO_SERVE_EN
    st_after_ticks = 3'd2;
`else
    st_after_ticks = 3'd1;
`endif
    chk("ticks.state", 8'(bus.state), 8'(st_after_ticks));

    // Randomised play against the model.
    for (int i = 0; i < 500; i++) begin
      cycle("rand",
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            ($urandom_range(0, 7) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0,
            ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Reach PLAY with 2/1, then reset mid-rally.
    do_reset("reset2");
    press("r2_start", 1);
    press("r2_serve", 1);
    cycle("r2_mr1", 0, 0, 1, 0, 0); idle("r2_pt");
    serve("r2_serve");
    cycle("r2_mr2", 0, 0, 1, 0, 0); idle("r2_pt");
    serve("r2_serve");
    cycle("r2_ml", 0, 1, 0, 0, 0); idle("r2_pt");
    serve("r2_serve");
    chk("midplay.state", 8'(bus.state), 8'd2);
    chk("midplay.scores", {bus.score_1, bus.score_2}, 8'h21);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    chk("async_reset.scores", {bus.score_1, bus.score_2}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    idle("post_reset");
    press("post_reset_start", 2);
    chk("post_reset.state", 8'(bus.state), 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
